// File: rtl/switch_stats_counter.sv
// Per-port weighted accept/drop/deliver counters for the switch.
// Saturating live bank, snapshot shadow bank, 1-cycle registered readout.
module switch_stats_counter #(
   parameter int NUM_PORTS     = 4,
   parameter int CNT_WIDTH     = 16,
   parameter int CLEAR_ON_SNAP = 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_PORTS-1:0]                valid_in,
   input  logic [NUM_PORTS*NUM_PORTS-1:0]      target_in,
   input  logic [NUM_PORTS-1:0]                fifo_full,
   input  logic [NUM_PORTS-1:0]                valid_out,
   input  logic                                snap_req,
   input  logic                                rd_en,
   input  logic [$clog2(NUM_PORTS)+1:0]        rd_addr,
   output logic [CNT_WIDTH-1:0]                rd_data,
   output logic                                rd_valid,
   output logic [NUM_PORTS-1:0]                sat_flag
);

   localparam int PW = $clog2(NUM_PORTS);
   localparam int W  = CNT_WIDTH;

   typedef logic [W-1:0] cnt_t;

   cnt_t        acc_q    [NUM_PORTS];
   cnt_t        drop_q   [NUM_PORTS];
   cnt_t        dlv_q    [NUM_PORTS];
   cnt_t        shadow_q [NUM_PORTS][4];
   cnt_t        status_c [NUM_PORTS];
   logic [W:0]  wt       [NUM_PORTS];
   logic [W:0]  res_acc  [NUM_PORTS];
   logic [W:0]  res_drop [NUM_PORTS];
   logic [W:0]  res_dlv  [NUM_PORTS];
   logic [W+4:0] st_ext  [NUM_PORTS];
   logic [NUM_PORTS-1:0] sat_d;
   cnt_t        rd_mux;
   logic        clr;

   assign clr = snap_req && (CLEAR_ON_SNAP != 0);

   // Bit W of the result flags an overflow; the value is clamped to all-ones.
   function automatic logic [W:0] add_sat(input cnt_t a, input logic [W:0] b);
      logic [W:0] s;
      s = {1'b0, a} + b;
      if (s[W]) s = '1;
      return s;
   endfunction

   always_comb begin
      sat_d = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         wt[p] = (W+1)'($countones(target_in[p*NUM_PORTS +: NUM_PORTS]));
         res_acc[p] = add_sat(clr ? '0 : acc_q[p],
                              (valid_in[p] && !fifo_full[p]) ? wt[p] : '0);
         res_drop[p] = add_sat(clr ? '0 : drop_q[p],
                               (valid_in[p] && fifo_full[p]) ? wt[p] : '0);
         res_dlv[p] = add_sat(clr ? '0 : dlv_q[p], (W+1)'(valid_out[p]));
         sat_d[p] = (clr ? 1'b0 : sat_flag[p])
                  | res_acc[p][W] | res_drop[p][W] | res_dlv[p][W];
         st_ext[p] = {W'(0), sat_flag[p], 2'b00, valid_in[p], fifo_full[p]};
         status_c[p] = st_ext[p][W-1:0];
      end
   end

   // Ports beyond NUM_PORTS match no entry and read as zero.
   always_comb begin
      rd_mux = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (rd_addr[PW+1:2] == PW'(p)) rd_mux = shadow_q[p][rd_addr[1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            acc_q[p]  <= '0;
            drop_q[p] <= '0;
            dlv_q[p]  <= '0;
            for (int s = 0; s < 4; s++) shadow_q[p][s] <= '0;
         end
         sat_flag <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            acc_q[p]  <= res_acc[p][W-1:0];
            drop_q[p] <= res_drop[p][W-1:0];
            dlv_q[p]  <= res_dlv[p][W-1:0];
            if (snap_req) begin
               shadow_q[p][0] <= acc_q[p];
               shadow_q[p][1] <= drop_q[p];
               shadow_q[p][2] <= dlv_q[p];
               shadow_q[p][3] <= status_c[p];
            end
         end
         sat_flag <= sat_d;
         rd_valid <= rd_en;
         rd_data  <= rd_en ? rd_mux : '0;
      end
   end

endmodule

// File: tb/tb_switch_stats_counter.sv
// Bench for switch_stats_counter: directed scenarios plus random traffic
// checked every cycle against an arithmetic model of the counters.
module tb_switch_stats_counter;

   localparam int NP   = 5;
   localparam int CW   = 6;
   localparam int AW   = $clog2(NP) + 2;
   localparam int MAXV = (1 << CW) - 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NP-1:0]      valid_in;
   logic [NP*NP-1:0]   target_in;
   logic [NP-1:0]      fifo_full;
   logic [NP-1:0]      valid_out;
   logic               snap_req;
   logic               rd_en;
   logic [AW-1:0]      rd_addr;
   logic [CW-1:0]      rd_data;
   logic               rd_valid;
   logic [NP-1:0]      sat_flag;

   int checks   = 0;
   int failures = 0;

   int m_live [NP][3];
   int m_sh   [NP][4];
   bit m_sat  [NP];
   bit exp_rv;
   int exp_rd;

   switch_stats_counter #(
      .NUM_PORTS(NP), .CNT_WIDTH(CW), .CLEAR_ON_SNAP(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .target_in(target_in),
      .fifo_full(fifo_full), .valid_out(valid_out), .snap_req(snap_req),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_valid(rd_valid), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void bump(int p, int k, int inc);
      int s;
      s = m_live[p][k] + inc;
      if (s > MAXV) begin
         m_live[p][k] = MAXV;
         m_sat[p] = 1'b1;
      end else begin
         m_live[p][k] = s;
      end
   endfunction

   // One clock: the model consumes the inputs seen at the edge, then outputs are compared.
   task automatic cycle();
      int port, sel, w;
      logic [NP-1:0] sf;
      @(posedge clk);
      if (!rst_n) begin
         for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < 3; k++) m_live[p][k] = 0;
            for (int k = 0; k < 4; k++) m_sh[p][k] = 0;
            m_sat[p] = 1'b0;
         end
         exp_rv = 1'b0;
         exp_rd = 0;
      end else begin
         exp_rv = rd_en;
         exp_rd = 0;
         if (rd_en) begin
            port = int'(rd_addr) / 4;
            sel  = int'(rd_addr) % 4;
            if (port < NP) exp_rd = m_sh[port][sel];
         end
         for (int p = 0; p < NP; p++) begin
            if (snap_req) begin
               for (int k = 0; k < 3; k++) m_sh[p][k] = m_live[p][k];
               m_sh[p][3] = (int'(m_sat[p]) * 16 + int'(valid_in[p]) * 2
                             + int'(fifo_full[p])) % (MAXV + 1);
               for (int k = 0; k < 3; k++) m_live[p][k] = 0;
               m_sat[p] = 1'b0;
            end
            w = $countones(target_in[p*NP +: NP]);
            if (valid_in[p] && !fifo_full[p]) bump(p, 0, w);
            if (valid_in[p] && fifo_full[p])  bump(p, 1, w);
            if (valid_out[p])                 bump(p, 2, 1);
         end
      end
      #1;
      check("rd_valid", rd_valid, exp_rv);
      if (exp_rv) check("rd_data", rd_data, exp_rd);
      for (int p = 0; p < NP; p++) sf[p] = m_sat[p];
      check("sat_flag", sat_flag, sf);
   endtask

   task automatic drive(input logic [NP-1:0] vi, input logic [NP*NP-1:0] tg,
                        input logic [NP-1:0] ff, input logic [NP-1:0] vo,
                        input logic sn, input logic re, input logic [AW-1:0] ad);
      valid_in  = vi;
      target_in = tg;
      fifo_full = ff;
      valid_out = vo;
      snap_req  = sn;
      rd_en     = re;
      rd_addr   = ad;
      cycle();
   endtask

   initial begin
      rst_n = 1'b0;
      drive('0, '0, '0, '0, 1'b0, 1'b0, '0);
      drive('0, '0, '0, '0, 1'b1, 1'b1, '0);
      check("reset_rd_data", rd_data, 0);
      rst_n = 1'b1;

      // port0 accepts three packets of weight 3
      repeat (3) drive(5'b00001, 25'b00111, '0, '0, 1'b0, 1'b0, '0);
      drive('0, '0, '0, '0, 1'b1, 1'b0, '0);
      drive('0, '0, '0, '0, 1'b0, 1'b1, 5'd0);
      check("t1_acc0", rd_data, 9);
      check("t1_rv", rd_valid, 1);
      drive('0, '0, '0, '0, 1'b0, 1'b0, '0);
      check("t1_rv_low", rd_valid, 0);

      // port2 drops two packets of weight 5
      repeat (2) drive(5'b00100, 25'h1F << 10, 5'b00100, '0, 1'b0, 1'b0, '0);
      drive('0, '0, '0, '0, 1'b1, 1'b0, '0);
      drive('0, '0, '0, '0, 1'b0, 1'b1, 5'd9);
      check("t2_drop2", rd_data, 10);
      drive('0, '0, '0, '0, 1'b0, 1'b1, 5'd8);
      check("t2_acc2", rd_data, 0);

      // deliveries on port3, snap in the fifth delivery cycle
      repeat (4) drive(5'b01000, '0, '0, 5'b01000, 1'b0, 1'b0, '0);
      drive(5'b00000, '0, '0, 5'b01000, 1'b1, 1'b0, '0);
      drive('0, '0, '0, '0, 1'b0, 1'b1, 5'd14);
      check("t3_dlv3", rd_data, 4);
      drive('0, '0, '0, '0, 1'b1, 1'b0, '0);
      drive('0, '0, '0, '0, 1'b0, 1'b1, 5'd14);
      check("t3_dlv3_again", rd_data, 1);

      // port1 saturates: 13 x 5 = 65 > 63
      repeat (12) drive(5'b00010, 25'h1F << 5, '0, '0, 1'b0, 1'b0, '0);
      check("t4_nosat", sat_flag[1], 0);
      drive(5'b00010, 25'h1F << 5, '0, '0, 1'b0, 1'b0, '0);
      check("t4_sat", sat_flag[1], 1);
      drive('0, '0, '0, '0, 1'b1, 1'b0, '0);
      check("t4_sat_clr", sat_flag[1], 0);
      drive('0, '0, '0, '0, 1'b0, 1'b1, 5'd7);
      check("t4_status1", rd_data, 16);
      drive('0, '0, '0, '0, 1'b0, 1'b1, 5'd4);
      check("t4_acc1", rd_data, MAXV);

      // ports beyond NUM_PORTS
      drive('0, '0, '0, '0, 1'b0, 1'b1, 5'd24);
      check("oor_data", rd_data, 0);
      check("oor_rv", rd_valid, 1);
      drive('0, '0, '0, '0, 1'b0, 1'b1, 5'd31);
      check("oor_data2", rd_data, 0);

      // reset in the middle of traffic
      repeat (3) drive('1, (NP*NP)'($urandom), '0, '1, 1'b0, 1'b0, '0);
      rst_n = 1'b0;
      drive('1, '1, 5'b00101, '1, 1'b1, 1'b1, 5'd4);
      check("t5_rv", rd_valid, 0);
      rst_n = 1'b1;
      drive('0, '0, '0, '0, 1'b1, 1'b0, '0);
      drive('0, '0, '0, '0, 1'b0, 1'b1, 5'd0);
      check("t5_acc0", rd_data, 0);
      drive('0, '0, '0, '0, 1'b0, 1'b1, 5'd18);
      check("t5_dlv4", rd_data, 0);
      check("t5_sat", sat_flag, 0);

      for (int i = 0; i < 4000; i++) begin
         rst_n = (i != 2000);
         drive(NP'($urandom), (NP*NP)'($urandom), NP'($urandom & $urandom),
               NP'($urandom), ($urandom_range(0, 19) == 0),
               1'($urandom_range(0, 1)), AW'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
